// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state codes, parity mode codes, frame length helper.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

  // Receiver FSM states, kept as plain constants so legacy tools can consume them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity mode codes derived from the PARITY string parameter.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Total bits on the wire per frame; the transmitter uses this to pace frames.
  function automatic int unsigned frame_len(input int unsigned bytesize,
                                            input int unsigned has_par,
                                            input int unsigned stopsize);
    return 1 + bytesize + has_par + stopsize;
  endfunction

endpackage

// File: rtl/uart_baud.sv
// Loadable down-counter for bit timing; zero_o is high while the count sits at 0.
// Latency: a value loaded in cycle t reads as zero_o in cycle t+val+1.
// Backpressure: none; load_i always wins over the decrement.
module uart_baud #(
  parameter int unsigned N_LOG = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [N_LOG-1:0] load_val_i,
  output logic             zero_o
);

  logic [N_LOG-1:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, start-edge detect, mid-bit sampling, parity/stop check, one-entry holding register.
// Latency: rx_valid rises one cycle after the stop-bit sample, i.e. N_BIT/2+(1+BYTESIZE+P)*N_BIT+1 after start detect.
// Backpressure: a frame completing while the holding register is full and not popped is dropped and sets status_ovr.
// Build option UART_RX_MAJORITY_EN: bit value is the 2-of-3 majority of the synchronised line over the last 3 cycles.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BYTESIZE = 8,
  parameter string       PARITY   = "NONE",
  parameter int unsigned STOPSIZE = 1,
  parameter int unsigned N_BIT    = 16,
  parameter int unsigned N_LOG    = $clog2(N_BIT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rxd,
  output logic [BYTESIZE-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_err_par,
  output logic                rx_err_frm,
  output logic                status_ovr,
  input  logic                ovr_clr,
  output logic                status_irq
);

  localparam logic [1:0] PAR_MODE = (PARITY == "EVEN") ? PAR_EVEN :
                                    (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
  localparam bit HAS_PAR  = (PAR_MODE != PAR_NONE);
  localparam bit ODD_MODE = (PAR_MODE == PAR_ODD);

  localparam logic [N_LOG-1:0] HALF_LOAD = N_LOG'(N_BIT / 2 - 1);
  localparam logic [N_LOG-1:0] FULL_LOAD = N_LOG'(N_BIT - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(BYTESIZE - 1);

  // Only the first stop bit is checked, so STOPSIZE matters solely for range validation here.
  if (BYTESIZE < 5 || BYTESIZE > 8 || STOPSIZE < 1 || STOPSIZE > 2 || N_BIT < 4) begin : g_param_check
    $error("uart_rx: unsupported parameter set");
  end

  // Line synchroniser and delayed copies; all reset to the idle (high) level.
  logic sync1_q, rxd_s_q, rxd_q;
  logic sample;

`ifdef UART_RX_MAJORITY_EN
  logic rxd_qq;

  // Extra history flop feeding the majority vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_qq <= 1'b1;
    end else begin
      rxd_qq <= rxd_q;
    end
  end

  assign sample = (rxd_s_q & rxd_q) | (rxd_s_q & rxd_qq) | (rxd_q & rxd_qq);
`else
  assign sample = rxd_s_q;
`endif

  // Two-stage synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_q   <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      rxd_s_q <= sync1_q;
      rxd_q   <= rxd_s_q;
    end
  end

  // Frame FSM state and bit timing.
  logic [2:0]          state_q, state_d;
  logic [BYTESIZE-1:0] shreg_q, shreg_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                par_err_q, par_err_d;
  logic                baud_load;
  logic [N_LOG-1:0]    baud_val;
  logic                baud_zero;
  logic                frame_done;
  logic                frm_err_new;

  uart_baud #(
    .N_LOG(N_LOG)
  ) u_baud (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (baud_load),
    .load_val_i (baud_val),
    .zero_o     (baud_zero)
  );

  // Frame sequencing: detect start, sample each bit at its centre, flag completion at the stop sample.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    par_err_d   = par_err_q;
    baud_load   = 1'b0;
    baud_val    = FULL_LOAD;
    frame_done  = 1'b0;
    frm_err_new = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Edge rule: a line that is already low (break) never re-triggers.
        if (rxd_q && !rxd_s_q) begin
          state_d   = ST_START;
          baud_load = 1'b1;
          baud_val  = HALF_LOAD;
        end
      end
      ST_START: begin
        if (baud_zero) begin
          if (sample) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            baud_load = 1'b1;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (baud_zero) begin
          shreg_d   = {sample, shreg_q[BYTESIZE-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          baud_load = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (baud_zero) begin
          par_err_d = ((^shreg_q) ^ sample) != ODD_MODE;
          baud_load = 1'b1;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Re-arm at mid stop bit so a following start edge is never missed.
        if (baud_zero) begin
          frame_done  = 1'b1;
          frm_err_new = ~sample;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and assembly registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_err_q <= par_err_d;
    end
  end

  // Holding register and sticky overrun.
  logic [BYTESIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_par_q, err_par_d;
  logic                err_frm_q, err_frm_d;
  logic                ovr_q, ovr_d;
  logic                ovr_set;

  // A completed frame loads unless the register is full and not being popped this cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    err_par_d = err_par_q;
    err_frm_d = err_frm_q;
    ovr_set   = 1'b0;
    if (frame_done) begin
      if (valid_q && !rx_ready) begin
        ovr_set = 1'b1;
      end else begin
        data_d    = shreg_q;
        valid_d   = 1'b1;
        err_par_d = par_err_q;
        err_frm_d = frm_err_new;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_err_par = err_par_q;
  assign rx_err_frm = err_frm_q;
  assign status_ovr = ovr_q;
  assign status_irq = valid_q | ovr_q;

endmodule
